// File: rtl/keypad_scan_controller_if.sv
// rtl/keypad_scan_controller_if.sv - key event handshake between the keypad scanner and its consumer
interface keypad_scan_controller_if;
  logic [3:0] key_code;
  logic       key_valid;
  logic       key_ready;
  logic       key_overrun;

  modport master (output key_code, output key_valid, output key_overrun, input key_ready);
  modport slave  (input key_code, input key_valid, input key_overrun, output key_ready);
endinterface

// File: rtl/keypad_scan_controller.sv
// rtl/keypad_scan_controller.sv - 4x4 keypad row scanner with whole-scan debounce and key event handshake
// Optional auto-repeat of a held key is enabled by defining KEYPAD_REPEAT_EN.
module keypad_scan_controller #(
  parameter int SCAN_DIV       = 1000,
  parameter int DEBOUNCE_SCANS = 8,
  parameter int REPEAT_DELAY   = 50,
  parameter int REPEAT_RATE    = 10
) (
  input  logic       clk,
  input  logic       reset,
  output logic [3:0] row_n,
  input  logic [3:0] col_n,
  keypad_scan_controller_if.master key
);
  localparam int DW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int CW = $clog2(DEBOUNCE_SCANS + 1);

  typedef enum logic [1:0] {IDLE, DEBOUNCE, PRESSED} state_t;

  logic [DW-1:0] div;
  logic [1:0]    row;
  logic [3:0]    col_s1, col_s2;
  logic [3:0]    hits_r0, hits_r1, hits_r2;
  logic          slot_end, scan_done;
  logic [15:0]   hits;
  logic [4:0]    n_hits;
  logic [3:0]    hit_code;
  logic          is_key, is_cand;

  state_t        state, state_nx;
  logic [3:0]    cand, cand_nx;
  logic [CW-1:0] cnt, cnt_nx, rel_cnt, rel_cnt_nx;
  logic          confirm;

  assign slot_end  = (div == DW'(SCAN_DIV - 1));
  assign scan_done = slot_end && (row == 2'd3);
  assign row_n     = ~(4'b0001 << row);

  always_ff @(posedge clk) begin
    if (reset) begin
      div     <= '0;
      row     <= 2'd0;
      col_s1  <= 4'hF;
      col_s2  <= 4'hF;
      hits_r0 <= 4'h0;
      hits_r1 <= 4'h0;
      hits_r2 <= 4'h0;
    end else begin
      col_s1 <= col_n;
      col_s2 <= col_s1;
      if (slot_end) begin
        div <= '0;
        row <= row + 2'd1;
        case (row)
          2'd0:    hits_r0 <= ~col_s2;
          2'd1:    hits_r1 <= ~col_s2;
          2'd2:    hits_r2 <= ~col_s2;
          default: ;
        endcase
      end else begin
        div <= div + DW'(1);
      end
    end
  end

  // Row 3 is taken straight from the synchronizer so the scan resolves on its own last cycle.
  assign hits = {~col_s2, hits_r2, hits_r1, hits_r0};

  always_comb begin
    n_hits   = 5'd0;
    hit_code = 4'h0;
    for (int i = 0; i < 16; i++) begin
      if (hits[i]) begin
        n_hits   = n_hits + 5'd1;
        hit_code = 4'(i);
      end
    end
  end

  assign is_key  = (n_hits == 5'd1);
  assign is_cand = is_key && (hit_code == cand);

`ifdef KEYPAD_REPEAT_EN
  localparam int RMAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
  localparam int RW   = $clog2(RMAX + 1);
  logic [RW-1:0] rpt_cnt, rpt_cnt_nx;
  logic          rpt_first, rpt_first_nx;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      cand    <= 4'h0;
      cnt     <= '0;
      rel_cnt <= '0;
`ifdef KEYPAD_REPEAT_EN
      rpt_cnt   <= '0;
      rpt_first <= 1'b0;
`endif
    end else begin
      state   <= state_nx;
      cand    <= cand_nx;
      cnt     <= cnt_nx;
      rel_cnt <= rel_cnt_nx;
`ifdef KEYPAD_REPEAT_EN
      rpt_cnt   <= rpt_cnt_nx;
      rpt_first <= rpt_first_nx;
`endif
    end
  end

  always_comb begin
    state_nx   = state;
    cand_nx    = cand;
    cnt_nx     = cnt;
    rel_cnt_nx = rel_cnt;
    confirm    = 1'b0;
`ifdef KEYPAD_REPEAT_EN
    rpt_cnt_nx   = rpt_cnt;
    rpt_first_nx = rpt_first;
`endif
    if (scan_done) begin
      case (state)
        IDLE: begin
          if (is_key) begin
            cand_nx = hit_code;
            if (DEBOUNCE_SCANS == 1) begin
              confirm    = 1'b1;
              rel_cnt_nx = '0;
              state_nx   = PRESSED;
            end else begin
              cnt_nx   = CW'(1);
              state_nx = DEBOUNCE;
            end
          end
        end
        DEBOUNCE: begin
          if (is_cand) begin
            if (cnt + CW'(1) == CW'(DEBOUNCE_SCANS)) begin
              confirm    = 1'b1;
              cnt_nx     = '0;
              rel_cnt_nx = '0;
              state_nx   = PRESSED;
            end else begin
              cnt_nx = cnt + CW'(1);
            end
          end else if (is_key) begin
            cand_nx = hit_code;
            cnt_nx  = CW'(1);
          end else begin
            cnt_nx   = '0;
            state_nx = IDLE;
          end
        end
        PRESSED: begin
          if (is_cand) begin
            rel_cnt_nx = '0;
          end else if (rel_cnt + CW'(1) == CW'(DEBOUNCE_SCANS)) begin
            rel_cnt_nx = '0;
            state_nx   = IDLE;
          end else begin
            rel_cnt_nx = rel_cnt + CW'(1);
          end
`ifdef KEYPAD_REPEAT_EN
          // Repeat timing runs for the whole PRESSED stay and restarts on every repeat event.
          if (state_nx != PRESSED) begin
            rpt_cnt_nx   = '0;
            rpt_first_nx = 1'b0;
          end else begin
            rpt_cnt_nx = rpt_cnt + RW'(1);
            if ((!rpt_first && rpt_cnt_nx == RW'(REPEAT_DELAY)) ||
                (rpt_first && rpt_cnt_nx == RW'(REPEAT_RATE))) begin
              confirm      = 1'b1;
              rpt_cnt_nx   = '0;
              rpt_first_nx = 1'b1;
            end
          end
`endif
        end
        default: state_nx = IDLE;
      endcase
    end
  end

  // An acceptance in the confirm cycle frees the slot, so the new key loads without overrun.
  always_ff @(posedge clk) begin
    if (reset) begin
      key.key_code    <= 4'h0;
      key.key_valid   <= 1'b0;
      key.key_overrun <= 1'b0;
    end else begin
      key.key_overrun <= 1'b0;
      if (confirm) begin
        if (!key.key_valid || key.key_ready) begin
          key.key_code  <= cand_nx;
          key.key_valid <= 1'b1;
        end else begin
          key.key_overrun <= 1'b1;
        end
      end else if (key.key_valid && key.key_ready) begin
        key.key_valid <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_keypad_scan_controller.sv
// tb/tb_keypad_scan_controller.sv - directed bench for keypad_scan_controller
module tb_keypad_scan_controller;
  localparam int SD = 4;
  localparam int SCAN = 4 * SD;
`ifdef KEYPAD_REPEAT_EN
  localparam int EXP_HOLD_EVENTS = 4;
`else
  localparam int EXP_HOLD_EVENTS = 1;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  row_n;
  logic [3:0]  col_n;
  logic [15:0] keys;
  int          total = 0;
  int          bad = 0;
  int          ev_cnt = 0;
  int          ov_cnt = 0;
  logic [3:0]  last_code = 4'h0;
  int          ev0, ov0;

  keypad_scan_controller_if kif ();

  keypad_scan_controller #(
    .SCAN_DIV(SD), .DEBOUNCE_SCANS(3), .REPEAT_DELAY(5), .REPEAT_RATE(2)
  ) dut (
    .clk(clk), .reset(reset), .row_n(row_n), .col_n(col_n), .key(kif.master)
  );

  always #5 clk = ~clk;

  // Passive keypad: a pressed key shorts its column to the driven row.
  always_comb begin
    col_n = 4'hF;
    for (int r = 0; r < 4; r++)
      if (!row_n[r]) col_n = col_n & ~keys[r*4 +: 4];
  end

  always @(posedge clk) begin
    if (!reset) begin
      if (kif.key_valid && kif.key_ready) begin
        ev_cnt    <= ev_cnt + 1;
        last_code <= kif.key_code;
      end
      if (kif.key_overrun) ov_cnt <= ov_cnt + 1;
    end
  end

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic nscan(input int n);
    repeat (n * SCAN) @(negedge clk);
  endtask

  initial begin
    logic [3:0] er;
    reset = 1'b1;
    keys = 16'h0;
    kif.key_ready = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_row_n", 16'(row_n), 16'hE);
    check("rst_valid", 16'(kif.key_valid), 16'h0);
    check("rst_code", 16'(kif.key_code), 16'h0);
    check("rst_overrun", 16'(kif.key_overrun), 16'h0);
    reset = 1'b0;

    // 1: row walk, four cycles per row
    for (int i = 0; i < SCAN; i++) begin
      if (i > 0) @(negedge clk);
      er = ~(4'b0001 << (i / SD));
      check("row_walk", 16'(row_n), 16'(er));
    end
    @(negedge clk);
    check("idle_events", 16'(ev_cnt), 16'd0);
    check("idle_overrun", 16'(ov_cnt), 16'd0);

    // 2: hold 4'h9 for 6 scans
    ev0 = ev_cnt;
    keys = 16'h0200;
    nscan(2);
    check("t2_not_yet", 16'(kif.key_valid), 16'h0);
    nscan(1);
    check("t2_valid", 16'(kif.key_valid), 16'h1);
    check("t2_code", 16'(kif.key_code), 16'h9);
    nscan(3);
    check("t2_one_event", 16'(ev_cnt - ev0), 16'd1);
    keys = 16'h0;
    nscan(4);

    // 3: bounce splits the debounce run
    ev0 = ev_cnt;
    keys = 16'h0200;
    nscan(2);
    keys = 16'h0;
    nscan(1);
    keys = 16'h0200;
    nscan(2);
    check("t3_no_early", 16'(ev_cnt - ev0), 16'd0);
    nscan(1);
    check("t3_valid", 16'(kif.key_valid), 16'h1);
    nscan(1);
    check("t3_one_event", 16'(ev_cnt - ev0), 16'd1);
    keys = 16'h0;
    nscan(4);

    // 4: overrun while consumer stalls
    ev0 = ev_cnt;
    ov0 = ov_cnt;
    kif.key_ready = 1'b0;
    keys = 16'h0020;
    nscan(3);
    check("t4_valid5", 16'(kif.key_valid), 16'h1);
    check("t4_code5", 16'(kif.key_code), 16'h5);
    keys = 16'h0;
    nscan(3);
    keys = 16'h0080;
    nscan(2);
    check("t4_no_ovr_yet", 16'(ov_cnt - ov0), 16'd0);
    nscan(1);
    check("t4_overrun", 16'(kif.key_overrun), 16'h1);
    check("t4_code_kept", 16'(kif.key_code), 16'h5);
    check("t4_valid_kept", 16'(kif.key_valid), 16'h1);
    nscan(1);
    check("t4_ovr_once", 16'(ov_cnt - ov0), 16'd1);
    check("t4_ovr_low", 16'(kif.key_overrun), 16'h0);
    kif.key_ready = 1'b1;
    @(negedge clk);
    check("t4_accept", 16'(ev_cnt - ev0), 16'd1);
    check("t4_acc_code", 16'(last_code), 16'h5);
    check("t4_drop", 16'(kif.key_valid), 16'h0);
    repeat (SCAN - 1) @(negedge clk);
    keys = 16'h0;
    nscan(4);
    check("t4_no_seven", 16'(ev_cnt - ev0), 16'd1);

    // 5: two keys together read as no key
    ev0 = ev_cnt;
    ov0 = ov_cnt;
    keys = 16'h8001;
    nscan(6);
    check("t5_no_event", 16'(ev_cnt - ev0), 16'd0);
    check("t5_no_ovr", 16'(ov_cnt - ov0), 16'd0);
    check("t5_valid", 16'(kif.key_valid), 16'h0);
    keys = 16'h0;
    nscan(4);

    // 6: long hold of 4'hA
    ev0 = ev_cnt;
    keys = 16'h0400;
    nscan(3);
    check("t6_valid", 16'(kif.key_valid), 16'h1);
    check("t6_code", 16'(kif.key_code), 16'hA);
    nscan(10);
    check("t6_events", 16'(ev_cnt - ev0), 16'(EXP_HOLD_EVENTS));
    keys = 16'h0;
    nscan(4);

    // 7: reset during debounce discards the candidate
    ev0 = ev_cnt;
    keys = 16'h0200;
    nscan(2);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("t7_row0", 16'(row_n), 16'hE);
    check("t7_valid_clr", 16'(kif.key_valid), 16'h0);
    nscan(2);
    check("t7_no_early", 16'(ev_cnt - ev0), 16'd0);
    check("t7_not_valid", 16'(kif.key_valid), 16'h0);
    nscan(1);
    check("t7_valid", 16'(kif.key_valid), 16'h1);
    check("t7_code", 16'(kif.key_code), 16'h9);
    nscan(1);
    check("t7_one_event", 16'(ev_cnt - ev0), 16'd1);
    keys = 16'h0;
    nscan(4);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
